alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_multicycle.sv | 152 +++++++++++++++
 tb/tb_alu_multicycle.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Handshaked ALU: single-cycle logic/arith ops and an optional shift-add multiplier.
// Define ALU_MUL_EN to build the multiplier (op 10); otherwise op 10 is illegal.
module alu_multicycle #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       nzp,
  output logic             busy
);

  localparam int unsigned ShW = $clog2(WIDTH);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpAnd  = 4'd1;
  localparam logic [3:0] OpNot  = 4'd2;
  localparam logic [3:0] OpPass = 4'd3;
  localparam logic [3:0] OpSub  = 4'd4;
  localparam logic [3:0] OpOr   = 4'd5;
  localparam logic [3:0] OpXor  = 4'd6;
  localparam logic [3:0] OpShl  = 4'd7;
  localparam logic [3:0] OpShr  = 4'd8;
  localparam logic [3:0] OpSra  = 4'd9;
  localparam logic [3:0] OpMul  = 4'd10;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       nzp_q;
  logic [WIDTH-1:0] alu_res;
  logic [ShW-1:0]   shamt;
  logic             accept;
  logic             load_result;
  logic             start_mul;

  function automatic logic [2:0] flags_of(input logic [WIDTH-1:0] r);
    if (r[WIDTH-1])   return 3'b100;
    else if (r == '0) return 3'b010;
    else              return 3'b001;
  endfunction

  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign result    = result_q;
  assign nzp       = nzp_q;
  assign shamt     = b[ShW-1:0];

  // Single-cycle datapath; MUL and illegal codes fall through to zero here.
  always_comb begin
    alu_res = '0;
    case (op)
      OpAdd:   alu_res = a + b;
      OpAnd:   alu_res = a & b;
      OpNot:   alu_res = ~a;
      OpPass:  alu_res = a;
      OpSub:   alu_res = a - b;
      OpOr:    alu_res = a | b;
      OpXor:   alu_res = a ^ b;
      OpShl:   alu_res = a << shamt;
      OpShr:   alu_res = a >> shamt;
      OpSra:   alu_res = $signed(a) >>> shamt;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int unsigned CntW = ShW;

  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q, acc_step;
  logic [CntW-1:0]  cnt_q;

  assign start_mul = (op == OpMul);
  assign acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // One multiplier bit per EXEC cycle; product is kept modulo 2^WIDTH.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (accept && start_mul) begin
      acc_q    <= '0;
      mcand_q  <= a;
      mplier_q <= b;
      cnt_q    <= '0;
    end else if (state_q == StExec) begin
      acc_q    <= acc_step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end
`else
  assign start_mul = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    load_result = 1'b0;
    result_d    = alu_res;
    case (state_q)
      StIdle, StDone: begin
        if ((state_q == StDone) && out_ready) state_d = StIdle;
        if (accept) begin
          if (start_mul) begin
            state_d = StExec;
          end else begin
            state_d     = StDone;
            load_result = 1'b1;
          end
        end
      end
`ifdef ALU_MUL_EN
      StExec: begin
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d     = StDone;
          load_result = 1'b1;
          result_d    = acc_step;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= StIdle;
      result_q <= '0;
      nzp_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      if (load_result) begin
        result_q <= result_d;
        nzp_q    <= flags_of(result_d);
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=16): vector table, hand sequences, random ops.
module tb_alu_multicycle;

  localparam int W = 16;
`ifdef ALU_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a, b;
  logic [3:0]    op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic [2:0]    nzp;
  logic          busy;

  int total = 0;
  int bad   = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .nzp      (nzp),
    .busy     (busy)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [2:0]   nzp;
    int           lat;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model from the operation definitions, independent of the RTL structure.
  function automatic logic [W-1:0] model(input logic [3:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    int unsigned sh;
    logic [W-1:0] r;
    logic [31:0]  p;
    sh = y % W;
    case (o)
      4'd0: r = x + y;
      4'd1: r = x & y;
      4'd2: r = ~x;
      4'd3: r = x;
      4'd4: r = x - y;
      4'd5: r = x | y;
      4'd6: r = x ^ y;
      4'd7: r = x << sh;
      4'd8: r = x >> sh;
      4'd9: begin
        r = x >> sh;
        if (x[W-1]) r = r | ~(16'hFFFF >> sh);
      end
      4'd10: begin
        p = 32'(x) * 32'(y);
        r = MulEn ? p[W-1:0] : '0;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] model_nzp(input logic [W-1:0] r);
    if (r == 0)            return 3'b010;
    else if (r >= 16'h8000) return 3'b100;
    else                   return 3'b001;
  endfunction

  // Called on a falling edge with the DUT able to accept; returns on the falling edge
  // where the result is first visible (out_ready is high, so it retires at the next rise).
  task automatic do_op(input string nm, input logic [3:0] o, input logic [W-1:0] ia,
                       input logic [W-1:0] ib, input logic [W-1:0] er, input logic [2:0] en,
                       input int el);
    int  lat;
    bit  done;
    check({nm, " in_ready"}, 32'(in_ready), 32'd1);
    op = o; a = ia; b = ib; in_valid = 1'b1; out_ready = 1'b1;
    lat  = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge Clk);
      in_valid = 1'b0;
      lat++;
      if (out_valid) begin
        done = 1'b1;
      end else begin
        check({nm, " busy"}, 32'(busy), 32'd1);
        check({nm, " in_ready low"}, 32'(in_ready), 32'd0);
        if (lat > 3 * W) begin
          total++;
          bad++;
          $display("FAIL %s timeout: got no out_valid after %0d cycles, required %0d", nm, lat,
                   el);
          done = 1'b1;
        end
      end
    end
    check({nm, " latency"}, 32'(lat), 32'(el));
    check({nm, " result"}, 32'(result), 32'(er));
    check({nm, " nzp"}, 32'(nzp), 32'(en));
  endtask

  initial begin
    logic [3:0]   ro;
    logic [W-1:0] ra, rb, rr;
    bit           seen;

    vecs[0]  = '{4'd0,  16'h7FFF, 16'h0001, 16'h8000, 3'b100, 1};
    vecs[1]  = '{4'd4,  16'd5,    16'd5,    16'h0000, 3'b010, 1};
    vecs[2]  = '{4'd9,  16'h8000, 16'h0003, 16'hF000, 3'b100, 1};
    vecs[3]  = '{4'd1,  16'hF0F0, 16'h3C3C, 16'h3030, 3'b001, 1};
    vecs[4]  = '{4'd2,  16'h00FF, 16'h0000, 16'hFF00, 3'b100, 1};
    vecs[5]  = '{4'd3,  16'h1234, 16'hFFFF, 16'h1234, 3'b001, 1};
    vecs[6]  = '{4'd5,  16'h00F0, 16'h0F00, 16'h0FF0, 3'b001, 1};
    vecs[7]  = '{4'd6,  16'hFFFF, 16'hFFFF, 16'h0000, 3'b010, 1};
    vecs[8]  = '{4'd7,  16'h0001, 16'h0013, 16'h0008, 3'b001, 1};
    vecs[9]  = '{4'd8,  16'h8000, 16'h000F, 16'h0001, 3'b001, 1};
    vecs[10] = '{4'd7,  16'h1234, 16'hFFF0, 16'h1234, 3'b001, 1};
    vecs[11] = '{4'd4,  16'h0000, 16'h0001, 16'hFFFF, 3'b100, 1};
    vecs[12] = '{4'd12, 16'h0005, 16'h0005, 16'h0000, 3'b010, 1};
    vecs[13] = '{4'd15, 16'hFFFF, 16'h0001, 16'h0000, 3'b010, 1};
    vecs[14] = '{4'd10, 16'd300,  16'd300,
                 MulEn ? 16'h5F90 : 16'h0000, MulEn ? 3'b001 : 3'b010, MulEn ? W + 1 : 1};

    Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    repeat (2) @(negedge Clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset nzp", 32'(nzp), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    Reset = 1'b0;
    @(negedge Clk);

    // Consecutive vectors are issued back-to-back from DONE, so no-bubble behaviour is covered.
    for (int i = 0; i < 15; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].nzp,
            vecs[i].lat);
    end

    // Stall in DONE: result held, later request ignored until retire.
    @(negedge Clk);
    op = 4'd2; a = 16'h00FF; b = '0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge Clk);
    check("hold first valid", 32'(out_valid), 32'd1);
    check("hold first nzp", 32'(nzp), 32'b100);
    op = 4'd0; a = 16'd1; b = 16'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check($sformatf("hold%0d valid", i), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d result", i), 32'(result), 32'hFF00);
      check($sformatf("hold%0d in_ready", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge Clk);
    check("retire valid", 32'(out_valid), 32'd0);
    check("retire busy", 32'(busy), 32'd0);
    check("retire result kept", 32'(result), 32'hFF00);

    // Reset while DONE with a simultaneous accept attempt.
    op = 4'd3; a = 16'h1234; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge Clk);
    check("pre-reset valid", 32'(out_valid), 32'd1);
    Reset = 1'b1; out_ready = 1'b1; in_valid = 1'b1; op = 4'd0; a = 16'd7; b = 16'd7;
    @(negedge Clk);
    check("rst accept valid", 32'(out_valid), 32'd0);
    check("rst accept result", 32'(result), 32'd0);
    check("rst accept nzp", 32'(nzp), 32'd0);
    check("rst accept busy", 32'(busy), 32'd0);
    check("rst accept in_ready", 32'(in_ready), 32'd1);
    Reset = 1'b0; in_valid = 1'b0;
    @(negedge Clk);

`ifdef ALU_MUL_EN
    do_op("pre-mul add", 4'd0, 16'd1, 16'd1, 16'd2, 3'b001, 1);
    @(negedge Clk);
    op = 4'd10; a = 16'd300; b = 16'd300; in_valid = 1'b1;
    @(negedge Clk);
    in_valid = 1'b0;
    repeat (6) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("mul abort valid", 32'(out_valid), 32'd0);
    check("mul abort result", 32'(result), 32'd0);
    check("mul abort busy", 32'(busy), 32'd0);
    check("mul abort in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (2 * W) begin
      @(negedge Clk);
      if (out_valid) seen = 1'b1;
    end
    check("mul abort no late valid", 32'(seen), 32'd0);
`endif

    for (int i = 0; i < 200; i++) begin
      ro = 4'($urandom_range(0, 15));
      if (i % 7 == 0) ro = 4'd10;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 11 == 0) rb = '0;
      rr = model(ro, ra, rb);
      do_op($sformatf("rnd%0d op%0d", i, ro), ro, ra, rb, rr, model_nzp(rr),
            (MulEn && ro == 4'd10) ? W + 1 : 1);
      if ($urandom_range(0, 3) == 0) @(negedge Clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
